// File: rtl/quiz_host_controller_if.sv
// Quiz host controller bus: player buttons and host pushbuttons in,
// lamp, display, lockout, pulses and scores out.
interface quiz_host_controller_if #(
   parameter int SCORE_W = 4
);
   logic [3:0]           player;
   logic                 host_start;
   logic                 host_correct;
   logic                 host_wrong;
   logic                 score_clr;
   logic                 arm;
   logic [3:0]           lamp;
   logic [3:0]           winner_code;
   logic [3:0]           lockout;
   logic                 buzz;
   logic                 timeout;
   logic                 round_done;
   logic [4*SCORE_W-1:0] scores;

   modport master (
      output player, host_start, host_correct, host_wrong, score_clr,
      input  arm, lamp, winner_code, lockout, buzz, timeout,
      input  round_done, scores
   );

   modport slave (
      input  player, host_start, host_correct, host_wrong, score_clr,
      output arm, lamp, winner_code, lockout, buzz, timeout,
      output round_done, scores
   );
endinterface

// File: rtl/quiz_host_controller.sv
// Quiz host controller: arms a round, resolves the first eligible press,
// times the answer window, applies verdicts, lockouts and saturating scores.
module quiz_host_controller #(
   parameter int ANSWER_CYCLES = 1000,
   parameter int SCORE_W       = 4,
   parameter int SYNC_STAGES   = 2
) (
   input logic                   clk,
   input logic                   reset_n,
   quiz_host_controller_if.slave bus
);
   localparam int TW = $clog2(ANSWER_CYCLES);
   localparam logic [TW-1:0] T_LOAD = TW'(ANSWER_CYCLES - 1);
   localparam logic [SCORE_W-1:0] S_MAX = '1;

   typedef enum logic [1:0] {IDLE, ARMED, ANSWER} state_t;

   state_t               state, state_n;
   logic [3:0]           sync [SYNC_STAGES];
   logic [3:0]           prev, edges;
   logic [TW-1:0]        timer, timer_n;
   logic [1:0]           win, win_n, cap;
   logic [3:0]           lamp, lamp_n;
   logic [3:0]           code, code_n;
   logic [3:0]           lock, lock_n;
   logic                 buzz, buzz_n;
   logic                 tout, tout_n;
   logic                 done, done_n;
   logic [4*SCORE_W-1:0] scores, scores_n;
   logic [3:0]           elig, lock_set;
   logic [SCORE_W-1:0]   cur;

   // button synchronizers followed by a registered rising-edge detect
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
         prev  <= '0;
         edges <= '0;
      end else begin
         sync[0] <= bus.player;
         for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
         prev  <= sync[SYNC_STAGES-1];
         edges <= sync[SYNC_STAGES-1] & ~prev;
      end
   end

   // next state, winner capture, verdicts, timer, lockout and scores
   always_comb begin
      state_n  = state;
      timer_n  = timer;
      win_n    = win;
      lamp_n   = lamp;
      code_n   = code;
      lock_n   = lock;
      scores_n = scores;
      buzz_n   = 1'b0;
      tout_n   = 1'b0;
      done_n   = 1'b0;
      elig     = edges & ~lock;
      lock_set = lock | (4'b0001 << win);
      cur      = scores[int'(win)*SCORE_W +: SCORE_W];
      priority case (1'b1)
         elig[3]: cap = 2'd3;
         elig[2]: cap = 2'd2;
         elig[1]: cap = 2'd1;
         default: cap = 2'd0;
      endcase
      unique case (state)
         IDLE: begin
            if (bus.score_clr) scores_n = '0;
            if (bus.host_start) begin
               lock_n  = '0;
               state_n = ARMED;
            end
         end
         ARMED: begin
            if (elig != 4'b0000) begin
               win_n   = cap;
               lamp_n  = 4'b0001 << cap;
               code_n  = {2'b00, cap} + 4'd1;
               buzz_n  = 1'b1;
               timer_n = T_LOAD;
               state_n = ANSWER;
            end
         end
         ANSWER: begin
            timer_n = timer - 1'b1;
            if (bus.host_wrong ||
                (timer == '0 && !bus.host_correct)) begin
               lock_n = lock_set;
               tout_n = !bus.host_wrong;
               lamp_n = '0;
               code_n = '0;
               if (&lock_set) begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n = ARMED;
               end
            end else if (bus.host_correct) begin
               if (cur != S_MAX)
                  scores_n[int'(win)*SCORE_W +: SCORE_W] = cur + 1'b1;
               lamp_n  = '0;
               code_n  = '0;
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // state and output registers; reset aborts any round silently
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         timer  <= '0;
         win    <= '0;
         lamp   <= '0;
         code   <= '0;
         lock   <= '0;
         buzz   <= 1'b0;
         tout   <= 1'b0;
         done   <= 1'b0;
         scores <= '0;
      end else begin
         state  <= state_n;
         timer  <= timer_n;
         win    <= win_n;
         lamp   <= lamp_n;
         code   <= code_n;
         lock   <= lock_n;
         buzz   <= buzz_n;
         tout   <= tout_n;
         done   <= done_n;
         scores <= scores_n;
      end
   end

   assign bus.arm         = (state == ARMED);
   assign bus.lamp        = lamp;
   assign bus.winner_code = code;
   assign bus.lockout     = lock;
   assign bus.buzz        = buzz;
   assign bus.timeout     = tout;
   assign bus.round_done  = done;
   assign bus.scores      = scores;
endmodule

// File: tb/tb_quiz_host_controller.sv
// Bench for quiz_host_controller: directed rounds, a per-cycle reference
// model of the round rules, and hand-computed literal expectations.
module tb_quiz_host_controller;
   localparam int AC = 8;
   localparam int SW = 4;
   localparam int SS = 2;
   localparam int SMAX = (1 << SW) - 1;
   localparam int M_IDLE = 0;
   localparam int M_ARMED = 1;
   localparam int M_ANSWER = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;

   quiz_host_controller_if #(.SCORE_W(SW)) bus();

   quiz_host_controller #(
      .ANSWER_CYCLES(AC),
      .SCORE_W(SW),
      .SYNC_STAGES(SS)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // reference model of the round rules
   int         m_mode;
   int         m_win;
   int         m_elapsed;
   logic [3:0] m_lock;
   int         m_score [4];
   bit         m_buzz, m_tout, m_done;
   logic [3:0] hist [SS+2];

   task automatic model_reset();
      m_mode = M_IDLE;
      m_win = -1;
      m_elapsed = 0;
      m_lock = '0;
      m_buzz = 0;
      m_tout = 0;
      m_done = 0;
      for (int i = 0; i < 4; i++) m_score[i] = 0;
      for (int i = 0; i < SS + 2; i++) hist[i] = '0;
   endtask

   task automatic model_step();
      logic [3:0] e, el;
      bit expired;
      e = hist[SS] & ~hist[SS+1];
      m_buzz = 0;
      m_tout = 0;
      m_done = 0;
      case (m_mode)
         M_IDLE: begin
            if (bus.score_clr)
               for (int i = 0; i < 4; i++) m_score[i] = 0;
            if (bus.host_start) begin
               m_lock = '0;
               m_mode = M_ARMED;
            end
         end
         M_ARMED: begin
            el = e & ~m_lock;
            if (el != 0) begin
               for (int i = 0; i < 4; i++) if (el[i]) m_win = i;
               m_mode = M_ANSWER;
               m_elapsed = 0;
               m_buzz = 1;
            end
         end
         default: begin
            expired = (m_elapsed == AC - 1);
            if (bus.host_wrong || (expired && !bus.host_correct)) begin
               m_lock[m_win] = 1'b1;
               m_tout = !bus.host_wrong;
               m_win = -1;
               if (m_lock == 4'hF) begin
                  m_done = 1;
                  m_mode = M_IDLE;
               end else begin
                  m_mode = M_ARMED;
               end
            end else if (bus.host_correct) begin
               if (m_score[m_win] < SMAX) m_score[m_win]++;
               m_win = -1;
               m_done = 1;
               m_mode = M_IDLE;
            end else begin
               m_elapsed++;
            end
         end
      endcase
      for (int i = SS + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bus.player;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
      end
   end

   // per-cycle comparison of every output against the model
   initial begin
      logic [3:0] x_lamp, x_code;
      logic [4*SW-1:0] x_sc;
      logic [31:0] want, got;
      forever begin
         @(negedge clk);
         cyc++;
         x_lamp = (m_win < 0) ? 4'b0 : 4'(1 << m_win);
         x_code = 4'(m_win + 1);
         for (int i = 0; i < 4; i++) x_sc[i*SW +: SW] = SW'(m_score[i]);
         want = {m_mode == M_ARMED, x_lamp, x_code, m_lock,
                 m_buzz, m_tout, m_done, x_sc};
         got  = {bus.arm, bus.lamp, bus.winner_code, bus.lockout,
                 bus.buzz, bus.timeout, bus.round_done, bus.scores};
         n_chk++;
         if (got === want) n_pass++;
         else $display("FAIL model cyc=%0d: got %h, want %h", cyc, got, want);
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_pulse();
      bus.host_start = 1'b1;
      step();
      bus.host_start = 1'b0;
   endtask

   task automatic correct_pulse();
      bus.host_correct = 1'b1;
      step();
      bus.host_correct = 1'b0;
   endtask

   task automatic win_round(int idx);
      start_pulse();
      bus.player = 4'(1 << idx);
      step(4);
      bus.player = '0;
      correct_pulse();
   endtask

   initial begin
      bus.player = '0;
      bus.host_start = 1'b0;
      bus.host_correct = 1'b0;
      bus.host_wrong = 1'b0;
      bus.score_clr = 1'b0;
      step(3);
      chk("rst_lamp", bus.lamp, 0);
      chk("rst_scores", bus.scores, 0);
      chk("rst_arm", bus.arm, 0);
      chk("rst_lockout", bus.lockout, 0);
      reset_n = 1'b1;
      step();

      start_pulse();
      chk("t1_arm", bus.arm, 1);
      bus.player = 4'b0010;
      step(3);
      chk("t1_latency", bus.lamp, 0);
      step();
      chk("t1_lamp", bus.lamp, 4'b0010);
      chk("t1_code", bus.winner_code, 2);
      chk("t1_buzz", bus.buzz, 1);
      bus.player = '0;
      step();
      chk("t1_buzz_once", bus.buzz, 0);
      correct_pulse();
      chk("t1_scores", bus.scores, 16'h0010);
      chk("t1_done", bus.round_done, 1);
      chk("t1_idle", bus.arm, 0);

      start_pulse();
      bus.player = 4'b0101;
      step(4);
      chk("t2_lamp", bus.lamp, 4'b0100);
      chk("t2_code", bus.winner_code, 3);
      bus.player = '0;
      bus.host_wrong = 1'b1;
      step();
      bus.host_wrong = 1'b0;
      chk("t2_lockout", bus.lockout, 4'b0100);
      chk("t2_rearm", bus.arm, 1);
      bus.player = 4'b0100;
      step(6);
      chk("t2_locked_ignored", bus.lamp, 0);
      bus.player = '0;
      step(2);
      bus.player = 4'b0001;
      step(4);
      chk("t2_p0_lamp", bus.lamp, 4'b0001);
      bus.player = '0;
      correct_pulse();
      chk("t2_scores", bus.scores, 16'h0011);

      start_pulse();
      for (int i = 0; i < 4; i++) begin
         bus.player = 4'(1 << i);
         step(4);
         chk("t3_lamp", bus.lamp, 32'(1 << i));
         bus.player = '0;
         step(7);
         chk("t3_no_early_timeout", bus.timeout, 0);
         step();
         chk("t3_timeout", bus.timeout, 1);
         chk("t3_lockout", bus.lockout, 32'((2 << i) - 1));
         chk("t3_done", bus.round_done, 32'(i == 3));
         chk("t3_arm", bus.arm, 32'(i != 3));
      end

      bus.player = 4'b1000;
      step(5);
      start_pulse();
      step(8);
      chk("t4_held_arm", bus.arm, 1);
      chk("t4_held_lamp", bus.lamp, 0);
      bus.player = '0;
      step(3);
      bus.player = 4'b1000;
      step(4);
      chk("t4_code", bus.winner_code, 4);
      bus.player = '0;
      correct_pulse();
      chk("t4_scores", bus.scores, 16'h1011);

      for (int r = 0; r < 14; r++) win_round(0);
      chk("t5_fifteen", bus.scores, 16'h101F);
      win_round(0);
      chk("t5_saturate", bus.scores, 16'h101F);
      bus.score_clr = 1'b1;
      bus.host_start = 1'b1;
      step();
      bus.score_clr = 1'b0;
      bus.host_start = 1'b0;
      chk("t5_clr_idle", bus.scores, 0);
      chk("t5_clr_start_arm", bus.arm, 1);
      bus.player = 4'b0010;
      step(4);
      bus.player = '0;
      correct_pulse();
      start_pulse();
      bus.score_clr = 1'b1;
      step();
      bus.score_clr = 1'b0;
      chk("t5_clr_armed", bus.scores, 16'h0010);

      bus.player = 4'b0100;
      step(4);
      chk("t6_lamp", bus.lamp, 4'b0100);
      bus.player = '0;
      bus.host_correct = 1'b1;
      bus.host_wrong = 1'b1;
      step();
      bus.host_correct = 1'b0;
      bus.host_wrong = 1'b0;
      chk("t6_both_lockout", bus.lockout, 4'b0100);
      chk("t6_both_scores", bus.scores, 16'h0010);
      chk("t6_both_arm", bus.arm, 1);
      bus.player = 4'b1000;
      step(4);
      chk("t6_p3_lamp", bus.lamp, 4'b1000);
      bus.player = '0;
      step(2);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_lamp", bus.lamp, 0);
      chk("t6_rst_code", bus.winner_code, 0);
      chk("t6_rst_scores", bus.scores, 0);
      chk("t6_rst_lockout", bus.lockout, 0);
      step(2);
      reset_n = 1'b1;
      step(2);
      chk("t6_idle", bus.arm, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
